// File: rtl/note_match_lanes.sv
// rtl/note_match_lanes.sv - per-lane rhythm note matcher with hit/miss classification and totals
//
// Ports:
//   clk, rst_n     : clock (posedge) and synchronous active-low reset
//   song_time      : current song time in ticks
//   note_edge      : per-lane press pulse
//   note_time      : per-lane head note time from the note buffer (all-ones = empty)
//   note_request   : per-lane pulse asking the buffer to advance past its head
//   match_valid    : per-lane pulse, a press was classified
//   match_hit      : per-lane hit (1) or stray press (0)
//   match_time     : per-lane matched note time (0 on stray)
//   match_delta    : per-lane signed song_time - match_time (0 on stray)
//   miss_valid     : per-lane pulse, a note expired unmatched
//   miss_time      : per-lane time of the missed note
//   hit_count      : saturating total of hits over all lanes
//   miss_count     : saturating total of misses over all lanes
module note_match_lanes #(
    parameter int LANES   = 5,
    parameter int TIME_W  = 18,
    parameter int TIMEOUT = 100,
    parameter int WINDOW  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TIME_W-1:0]             song_time,
    input  logic [LANES-1:0]              note_edge,
    input  logic [LANES*TIME_W-1:0]       note_time,
    output logic [LANES-1:0]              note_request,
    output logic [LANES-1:0]              match_valid,
    output logic [LANES-1:0]              match_hit,
    output logic [LANES*TIME_W-1:0]       match_time,
    output logic [LANES*(TIME_W+1)-1:0]   match_delta,
    output logic [LANES-1:0]              miss_valid,
    output logic [LANES*TIME_W-1:0]       miss_time,
    output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count
);

    localparam int                DW     = TIME_W + 1;
    localparam logic [TIME_W-1:0] EMPTY  = '1;
    localparam logic [DW-1:0]     WIN    = DW'(WINDOW);
    localparam logic [TIME_W-1:0] TMO    = TIME_W'(TIMEOUT);

    logic [LANES-1:0] hit_c;
    logic [LANES-1:0] miss_c;

    // Distance is taken one bit wider so the sign of the difference survives.
    function automatic logic [DW-1:0] abs_diff(input logic [TIME_W-1:0] a,
                                               input logic [TIME_W-1:0] b);
        logic [DW-1:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[DW-1] ? -d : d;
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] cnt,
                                         input logic [LANES-1:0] ev);
        logic [16:0] sum;
        sum = {1'b0, cnt};
        for (int i = 0; i < LANES; i++) begin
            sum = sum + 17'(ev[i]);
        end
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [TIME_W-1:0] nt;
        logic [TIME_W-1:0] past_q;
        logic              past_valid_q;
        logic              pend_q;
        logic              fut_valid;
        logic [DW-1:0]     dp;
        logic [DW-1:0]     df;
        logic              use_past;
        logic              in_window;
        logic              hit;
        logic              hit_past;
        logic              hit_fut;
        logic              promote;
        logic              timeout;
        logic              miss;
        logic              request;
        logic [TIME_W-1:0] cand_time;

        logic              req_q;
        logic              mv_q;
        logic              mh_q;
        logic [TIME_W-1:0] mt_q;
        logic [DW-1:0]     md_q;
        logic              xv_q;
        logic [TIME_W-1:0] xt_q;

        assign nt        = note_time[g*TIME_W +: TIME_W];
        // The head is hidden while a request is outstanding: the buffer has
        // not yet presented the replacement note.
        assign fut_valid = (nt != EMPTY) && !pend_q;
        assign dp        = abs_diff(song_time, past_q);
        assign df        = abs_diff(nt, song_time);
        // Ties go to the past note; an absent future never wins.
        assign use_past  = past_valid_q && (!fut_valid || dp <= df);
        assign in_window = use_past ? (dp <= WIN) : (fut_valid && df <= WIN);
        assign hit       = note_edge[g] && in_window;
        assign hit_past  = hit && use_past;
        assign hit_fut   = hit && !use_past;
        assign promote   = fut_valid && (nt <= song_time) && !hit_fut;
        // Unsigned wrap-around difference, so a song-time rollover still ages notes.
        assign timeout   = past_valid_q && ((song_time - past_q) > TMO);
        // A past hit this cycle consumes the note, so neither promotion
        // nor timeout can report it as missed.
        assign miss      = past_valid_q && !hit_past && (promote || timeout);
        assign request   = promote || hit_fut;
        assign cand_time = use_past ? past_q : nt;

        assign hit_c[g]  = hit;
        assign miss_c[g] = miss;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                past_q       <= '0;
                past_valid_q <= 1'b0;
                pend_q       <= 1'b0;
                req_q        <= 1'b0;
                mv_q         <= 1'b0;
                mh_q         <= 1'b0;
                mt_q         <= '0;
                md_q         <= '0;
                xv_q         <= 1'b0;
                xt_q         <= '0;
            end else begin
                pend_q <= request;
                if (promote) begin
                    past_q       <= nt;
                    past_valid_q <= 1'b1;
                end else if (hit_past || timeout) begin
                    past_valid_q <= 1'b0;
                end
                req_q <= request;
                mv_q  <= note_edge[g];
                mh_q  <= hit;
                mt_q  <= hit ? cand_time : '0;
                md_q  <= hit ? ({1'b0, song_time} - {1'b0, cand_time}) : '0;
                xv_q  <= miss;
                xt_q  <= miss ? past_q : '0;
            end
        end

        assign note_request[g]                 = req_q;
        assign match_valid[g]                  = mv_q;
        assign match_hit[g]                    = mh_q;
        assign match_time[g*TIME_W +: TIME_W]  = mt_q;
        assign match_delta[g*DW +: DW]         = md_q;
        assign miss_valid[g]                   = xv_q;
        assign miss_time[g*TIME_W +: TIME_W]   = xt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= bump(hit_count, hit_c);
            miss_count <= bump(miss_count, miss_c);
        end
    end

endmodule
